hs_out_fifo: RTL

Elastic buffer between a dataflow graph's output port (the `dout_req_N`/`dout_ack_N`/`dout_N` triple of the arf top level) and the bench consumer.
- Upstream side: acts as a consumer. Drives req, receives an ack pulse with data.
- Downstream side: acts as a producer. Receives req, returns an ack pulse with data.
- Purpose: decouple graph output from consumer stalls (fail_rate > 0) so throughput measurements reflect graph capacity.
- Storage: DEPTH-entry circular buffer with in-order delivery.

---
 rtl/hs_out_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hs_out_fifo.sv
`default_nettype none
// ============================================================================
// hs_out_fifo : req/ack elastic buffer between a graph output port and a
//               consumer. Optional counters: HS_OUT_FIFO_STATS_EN.
// Revision    : 1.0
// ============================================================================
module hs_out_fifo #(
   parameter int data_width = 32,
   parameter int DEPTH      = 4,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  up_req,
   input  logic                  up_ack,
   input  logic [data_width-1:0] up_din,
   input  logic                  dn_req,
   output logic                  dn_ack,
   output logic [data_width-1:0] dn_dout,
   output logic [AW:0]           occupancy,
   output logic                  overflow,
   output logic [31:0]           stat_in,
   output logic [31:0]           stat_out
);

   localparam logic [AW:0] c_full      = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_req_limit = (AW+1)'(DEPTH - 2);

   logic [data_width-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           occ_q, occ_d;
   logic                  ack_q;
   logic                  up_req_q, up_req_d;
   logic                  dn_ack_q;
   logic                  ovf_q;
   logic [data_width-1:0] dout_q;

   logic                  ack_rise;
   logic                  full;
   logic                  push;
   logic                  pop;

   // An ack held for several cycles is one transfer: only its rising edge pushes.
   assign ack_rise = up_ack & ~ack_q;
   assign full     = (occ_q == c_full);
   assign push     = ack_rise & ~full;
   assign pop      = dn_req & ~dn_ack_q & (occ_q != '0);

   // Drop req one slot early so an ack already in flight still has room.
   always_comb begin
      occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
      up_req_d = (occ_d <= c_req_limit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         up_req_q <= 1'b0;
         dn_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         ack_q    <= up_ack;
         occ_q    <= occ_d;
         up_req_q <= up_req_d;
         dn_ack_q <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (ack_rise && full) begin
            ovf_q <= 1'b1;
         end
         if (pop) begin
            dout_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= up_din;
      end
   end

   assign up_req    = up_req_q;
   assign dn_ack    = dn_ack_q;
   assign dn_dout   = dout_q;
   assign occupancy = occ_q;
   assign overflow  = ovf_q;

`ifdef HS_OUT_FIFO_STATS_EN
   logic [31:0] stat_in_q, stat_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_in_q  <= '0;
         stat_out_q <= '0;
      end else begin
         if (push) begin
            stat_in_q <= stat_in_q + 32'd1;
         end
         if (pop) begin
            stat_out_q <= stat_out_q + 32'd1;
         end
      end
   end

   assign stat_in  = stat_in_q;
   assign stat_out = stat_out_q;
`else
   assign stat_in  = '0;
   assign stat_out = '0;
`endif

endmodule
`default_nettype wire
